// File: rtl/fwd_pkg.sv
// Shared types for the forwarding / load-use hazard unit: select codes,
// shadow-slot payload and the slot match helper.
package fwd_pkg;

  localparam int unsigned FWD_SEL_W = 2;
  localparam int unsigned FWD_RD_W  = 8;

  typedef enum logic [FWD_SEL_W-1:0] {
    FWD_RF   = 2'd0,
    FWD_EXMR = 2'd1,
    FWD_MRWB = 2'd2,
    FWD_PC   = 2'd3
  } fwd_sel_e;

  typedef struct packed {
    logic                valid;
    logic [FWD_RD_W-1:0] rd;
    logic                wr;
    logic                is_load;
  } fwd_slot_t;

  // PC exclusion is handled by the caller, which checks the PC index first.
  function automatic logic slot_produces(input fwd_slot_t slot, input logic [FWD_RD_W-1:0] r);
    return slot.valid && slot.wr && (slot.rd == r);
  endfunction

endpackage

// File: rtl/fwd_src_sel.sv
// Per-source forwarding select: PC first, then youngest producer (EX) over MR.
module fwd_src_sel
  import fwd_pkg::*;
#(
  parameter int unsigned RW     = 3,
  parameter int unsigned PC_REG = 7
) (
  input  logic [RW-1:0] rs_i,
  input  logic          rs_used_i,
  input  fwd_slot_t     ex_slot_i,
  input  fwd_slot_t     mr_slot_i,
  output fwd_sel_e      sel_c
);

  logic [FWD_RD_W-1:0] rs_ext;
  logic                unused_load_c;

  assign rs_ext        = FWD_RD_W'(rs_i);
  assign unused_load_c = ^{ex_slot_i.is_load, mr_slot_i.is_load};

  always_comb begin
    sel_c = FWD_RF;
    if (rs_i == RW'(PC_REG)) begin
      sel_c = FWD_PC;
    end else if (rs_used_i && slot_produces(ex_slot_i, rs_ext)) begin
      sel_c = FWD_EXMR;
    end else if (rs_used_i && slot_produces(mr_slot_i, rs_ext)) begin
      sel_c = FWD_MRWB;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard controller beside RR: shadows EX/MR/WB
// destination tags, registers per-source selects into EX and counts stalls.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int unsigned NREG   = 8,
  parameter int unsigned NSRC   = 2,
  parameter int unsigned PC_REG = 7,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rr_valid,
  input  logic [NSRC*$clog2(NREG)-1:0]   rr_rs,
  input  logic [NSRC-1:0]                rr_rs_used,
  input  logic [$clog2(NREG)-1:0]        rr_rd,
  input  logic                           rr_reg_wr,
  input  logic                           rr_is_load,
  input  logic                           pipe_hold,
  input  logic                           flush,
  output logic                           stall_rr,
  output logic [NSRC*FWD_SEL_W-1:0]      ex_sel,
  output logic                           ex_bubble,
  output logic [CNT_W-1:0]               stall_cnt
);

  localparam int unsigned RW = $clog2(NREG);

  fwd_slot_t                    ex_q, ex_d, mr_q, mr_d, wb_q, wb_d;
  logic [NSRC*FWD_SEL_W-1:0]    ex_sel_q, ex_sel_d, sel_vec_c;
  logic                         ex_bubble_q, ex_bubble_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         ld_hit_c, issue_c;
  fwd_sel_e                     sel_src [NSRC];
  // WB shadow is never consulted: the register file is write-first.
  logic                         unused_wb_c;

  assign unused_wb_c = ^wb_q;

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    fwd_src_sel #(.RW(RW), .PC_REG(PC_REG)) u_sel (
      .rs_i      (rr_rs[g*RW +: RW]),
      .rs_used_i (rr_rs_used[g]),
      .ex_slot_i (ex_q),
      .mr_slot_i (mr_q),
      .sel_c     (sel_src[g])
    );
    assign sel_vec_c[g*FWD_SEL_W +: FWD_SEL_W] = sel_src[g];
  end

  // Any used, non-PC source that names the destination of the load in EX.
  always_comb begin
    ld_hit_c = 1'b0;
    for (int unsigned s = 0; s < NSRC; s++) begin
      if (rr_rs_used[s] && (rr_rs[s*RW +: RW] != RW'(PC_REG)) &&
          (ex_q.rd == FWD_RD_W'(rr_rs[s*RW +: RW]))) begin
        ld_hit_c = 1'b1;
      end
    end
  end

  assign stall_rr = rr_valid && !flush && ex_q.valid && ex_q.is_load && ex_q.wr && ld_hit_c;
  assign issue_c  = rr_valid && !flush && !stall_rr;

  always_comb begin
    ex_d        = ex_q;
    mr_d        = mr_q;
    wb_d        = wb_q;
    ex_sel_d    = ex_sel_q;
    ex_bubble_d = ex_bubble_q;
    cnt_d       = cnt_q;
    if (!pipe_hold) begin
      wb_d        = mr_q;
      mr_d        = ex_q;
      ex_d        = '0;
      ex_sel_d    = '0;
      ex_bubble_d = 1'b1;
      if (issue_c) begin
        ex_d.valid   = 1'b1;
        ex_d.rd      = FWD_RD_W'(rr_rd);
        ex_d.wr      = rr_reg_wr;
        ex_d.is_load = rr_is_load;
        ex_sel_d     = sel_vec_c;
        ex_bubble_d  = 1'b0;
      end
      if (stall_rr && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q        <= '0;
      mr_q        <= '0;
      wb_q        <= '0;
      ex_sel_q    <= '0;
      ex_bubble_q <= 1'b1;
      cnt_q       <= '0;
    end else begin
      ex_q        <= ex_d;
      mr_q        <= mr_d;
      wb_q        <= wb_d;
      ex_sel_q    <= ex_sel_d;
      ex_bubble_q <= ex_bubble_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ex_sel    = ex_sel_q;
  assign ex_bubble = ex_bubble_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: pipeline-history model compared
// every cycle, plus directed vectors with hand-computed expectations.
module tb_fwd_hazard_unit;

  localparam int RW   = 3;
  localparam int NSRC = 2;
  localparam int PC   = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rr_valid = 1'b0;
  logic [5:0] rr_rs = '0;
  logic [1:0] rr_rs_used = '0;
  logic [2:0] rr_rd = '0;
  logic       rr_reg_wr = 1'b0;
  logic       rr_is_load = 1'b0;
  logic       pipe_hold = 1'b0;
  logic       flush = 1'b0;

  logic        stall_rr, ex_bubble;
  logic [3:0]  ex_sel;
  logic [15:0] stall_cnt;
  logic        stall_rr_s, ex_bubble_s;
  logic [3:0]  ex_sel_s;
  logic [1:0]  stall_cnt_s;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit dut (
    .clk(clk), .rst(rst), .rr_valid(rr_valid), .rr_rs(rr_rs), .rr_rs_used(rr_rs_used),
    .rr_rd(rr_rd), .rr_reg_wr(rr_reg_wr), .rr_is_load(rr_is_load), .pipe_hold(pipe_hold),
    .flush(flush), .stall_rr(stall_rr), .ex_sel(ex_sel), .ex_bubble(ex_bubble),
    .stall_cnt(stall_cnt)
  );

  fwd_hazard_unit #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .rr_valid(rr_valid), .rr_rs(rr_rs), .rr_rs_used(rr_rs_used),
    .rr_rd(rr_rd), .rr_reg_wr(rr_reg_wr), .rr_is_load(rr_is_load), .pipe_hold(pipe_hold),
    .flush(flush), .stall_rr(stall_rr_s), .ex_sel(ex_sel_s), .ex_bubble(ex_bubble_s),
    .stall_cnt(stall_cnt_s)
  );

  // Model: history of the two youngest in-flight instructions (0 = EX, 1 = MR).
  typedef struct { bit v; int rd; bit wr; bit ld; } rec_t;
  rec_t pipe [2];
  int   m_sel = 0;
  bit   m_bub = 1'b1;
  int   m_cnt = 0;
  int   m_sat = 0;

  function automatic int src_of(input int s);
    return int'((rr_rs >> (s * RW)) & 6'd7);
  endfunction

  function automatic bit model_stall();
    bit hit = 1'b0;
    for (int s = 0; s < NSRC; s++) begin
      if (rr_rs_used[s] && src_of(s) != PC && src_of(s) == pipe[0].rd) hit = 1'b1;
    end
    return rr_valid && !flush && pipe[0].v && pipe[0].ld && pipe[0].wr && hit;
  endfunction

  // Scan oldest to youngest so the youngest producer overrides.
  function automatic int model_sel();
    int res = 0;
    for (int s = 0; s < NSRC; s++) begin
      int code = 0;
      if (src_of(s) == PC) code = 3;
      else if (rr_rs_used[s]) begin
        for (int age = 1; age >= 0; age--) begin
          if (pipe[age].v && pipe[age].wr && pipe[age].rd == src_of(s)) code = age + 1;
        end
      end
      res = res | (code << (2 * s));
    end
    return res;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) pipe[i] = '{1'b0, 0, 1'b0, 1'b0};
      m_sel = 0; m_bub = 1'b1; m_cnt = 0; m_sat = 0;
    end else if (!pipe_hold) begin
      bit st;
      bit take;
      st   = model_stall();
      take = rr_valid && !flush && !st;
      if (st) begin
        m_cnt = (m_cnt == 65535) ? m_cnt : m_cnt + 1;
        m_sat = (m_sat == 3) ? m_sat : m_sat + 1;
      end
      m_sel   = take ? model_sel() : 0;
      m_bub   = !take;
      pipe[1] = pipe[0];
      pipe[0] = take ? '{1'b1, int'(rr_rd), rr_reg_wr, rr_is_load} : '{1'b0, 0, 1'b0, 1'b0};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    check("cmp_stall_rr", 32'(stall_rr), 32'(model_stall()));
    check("cmp_ex_sel", 32'(ex_sel), 32'(m_sel));
    check("cmp_ex_bubble", 32'(ex_bubble), 32'(m_bub));
    check("cmp_stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    check("cmp_sat_ex_sel", 32'(ex_sel_s), 32'(m_sel));
    check("cmp_sat_cnt", 32'(stall_cnt_s), 32'(m_sat));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ins(input int r0, input int r1, input int u, input int rd, input bit wr, input bit ld);
    rr_valid   = 1'b1;
    rr_rs      = {3'(r1), 3'(r0)};
    rr_rs_used = 2'(u);
    rr_rd      = 3'(rd);
    rr_reg_wr  = wr;
    rr_is_load = ld;
    pipe_hold  = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic nop();
    ins(0, 0, 0, 0, 1'b0, 1'b0);
    rr_valid = 1'b0;
  endtask

  task automatic load_use(input int rd);
    ins(0, 0, 1, rd, 1'b1, 1'b1); tick();
    ins(rd, 0, 1, 0, 1'b0, 1'b0); tick();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ex_sel", 32'(ex_sel), 32'h0);
    check("reset_ex_bubble", 32'(ex_bubble), 32'h1);
    check("reset_stall_cnt", 32'(stall_cnt), 32'h0);
    check("reset_stall_rr", 32'(stall_rr), 32'h0);
    rst = 1'b0;

    // Back-to-back dependency: EX/MR forward on both sources.
    ins(0, 0, 3, 1, 1'b1, 1'b0); tick();
    ins(1, 1, 3, 2, 1'b1, 1'b0); tick();
    check("dep_dist1", 32'(ex_sel), 32'h5);
    check("dep_dist1_bubble", 32'(ex_bubble), 32'h0);

    // One unrelated instruction between: MR/WB forward.
    ins(0, 0, 3, 3, 1'b1, 1'b0); tick();
    ins(5, 6, 3, 4, 1'b1, 1'b0); tick();
    ins(3, 3, 3, 5, 1'b0, 1'b0); tick();
    check("dep_dist2", 32'(ex_sel), 32'hA);

    // Two between: register file supplies the value.
    ins(0, 0, 3, 6, 1'b1, 1'b0); tick();
    ins(0, 0, 3, 4, 1'b1, 1'b0); tick();
    ins(0, 0, 3, 5, 1'b1, 1'b0); tick();
    ins(6, 6, 3, 0, 1'b0, 1'b0); tick();
    check("dep_dist3", 32'(ex_sel), 32'h0);

    // Load-use: one stall, bubble, then MR/WB forward.
    ins(0, 0, 1, 3, 1'b1, 1'b1); tick();
    ins(3, 5, 3, 4, 1'b1, 1'b0);
    #1 check("lu_stall", 32'(stall_rr), 32'h1);
    tick();
    check("lu_bubble", 32'(ex_bubble), 32'h1);
    check("lu_cnt", 32'(stall_cnt), 32'h1);
    check("lu_stall_gone", 32'(stall_rr), 32'h0);
    tick();
    check("lu_sel", 32'(ex_sel), 32'h2);
    check("lu_consumer_valid", 32'(ex_bubble), 32'h0);

    // r2 in EX and MR: youngest wins; r7 reads as PC even with a pending write.
    ins(0, 0, 3, 2, 1'b1, 1'b0); tick();
    ins(0, 0, 3, 2, 1'b1, 1'b0); tick();
    ins(2, 7, 3, 7, 1'b1, 1'b0); tick();
    check("ex_over_mr_pc", 32'(ex_sel), 32'hD);
    ins(2, 7, 1, 0, 1'b0, 1'b0); tick();
    check("pc_unused_src", 32'(ex_sel), 32'hE);

    // Load-use under a 3-cycle hold: counts once, after release.
    ins(0, 0, 1, 1, 1'b1, 1'b1); tick();
    ins(1, 0, 1, 0, 1'b0, 1'b0);
    pipe_hold = 1'b1;
    #1 check("hold_stall", 32'(stall_rr), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_stall_kept", 32'(stall_rr), 32'h1);
      check("hold_cnt_frozen", 32'(stall_cnt), 32'h1);
    end
    pipe_hold = 1'b0;
    tick();
    check("hold_release_cnt", 32'(stall_cnt), 32'h2);
    check("hold_release_bubble", 32'(ex_bubble), 32'h1);
    tick();
    check("hold_consumer_sel", 32'(ex_sel), 32'h2);

    // Flush coincident with a load-use hazard.
    ins(0, 0, 1, 2, 1'b1, 1'b1); tick();
    ins(2, 0, 1, 0, 1'b0, 1'b0);
    flush = 1'b1;
    #1 check("flush_masks_stall", 32'(stall_rr), 32'h0);
    tick();
    check("flush_bubble", 32'(ex_bubble), 32'h1);
    check("flush_cnt", 32'(stall_cnt), 32'h2);
    nop(); tick();

    // Saturation on the 2-bit counter instance.
    load_use(3);
    load_use(4);
    check("sat_cnt", 32'(stall_cnt_s), 32'h3);
    check("wide_cnt", 32'(stall_cnt), 32'h4);

    // Asynchronous reset mid-stream, then normal restart.
    ins(0, 0, 3, 1, 1'b1, 1'b0); tick();
    check("pre_rst_bubble", 32'(ex_bubble), 32'h0);
    #1 rst = 1'b1;
    #1;
    check("arst_ex_sel", 32'(ex_sel), 32'h0);
    check("arst_ex_bubble", 32'(ex_bubble), 32'h1);
    check("arst_cnt", 32'(stall_cnt), 32'h0);
    check("arst_sat_cnt", 32'(stall_cnt_s), 32'h0);
    check("arst_stall_rr", 32'(stall_rr), 32'h0);
    tick();
    rst = 1'b0;
    ins(0, 0, 3, 2, 1'b1, 1'b0); tick();
    check("post_rst_load", 32'(ex_bubble), 32'h0);
    ins(2, 2, 3, 0, 1'b0, 1'b0); tick();
    check("post_rst_fwd", 32'(ex_sel), 32'h5);
    nop(); tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and load-use hazard controller for the pipelined IITB-RISC core, sitting beside the RR (register-read) stage. It keeps its own shadow of the destination tags of the instructions in EX, MR and WB, so the datapath only supplies per-instruction decode information at RR. From that shadow it registers per-source forwarding selects into EX, detects load-use hazards and stalls RR for one cycle, and counts hazard stalls.

## Interface
- NREG, 8: architectural register count; RW = $clog2(NREG).
- NSRC, 2: source operands per instruction.
- PC_REG, 7: register index that reads as PC (always select 3).
- CNT_W, 16: width of the stall counter.

- clk  in  1  core clock.
- rst  in  1  reset, asynchronous, active-high.
- rr_valid  in  1  valid instruction in RR.
- rr_rs  in  NSRC*RW  source indices; source s is bits [s*RW +: RW].
- rr_rs_used  in  NSRC  bit s set when source s is actually read.
- rr_rd  in  RW  destination index.
- rr_reg_wr  in  1  instruction writes rr_rd.
- rr_is_load  in  1  instruction is a load (data available only at MR/WB).
- pipe_hold  in  1  global freeze, e.g. memory wait.
- flush  in  1  squash the instruction in RR (branch/jump taken).
- stall_rr  out  1  load-use stall: hold IF/RR, inject a bubble into EX (combinational).
- ex_sel  out  NSRC*2  registered forwarding selects for the instruction in EX.
- ex_bubble  out  1  registered; EX holds an injected bubble or a squashed slot.
- stall_cnt  out  CNT_W  saturating count of load-use stall cycles.

## Operation
- Shadow slots EX, MR, WB, each {valid, rd, wr, is_load}; a slot "produces r" when valid && wr && rd == r && r != PC_REG.
- ex_sel codes per source: 0 register file, 1 EX/MR latch, 2 MR/WB latch, 3 PC.
- Select for source s computed from the current slots: rs == PC_REG -> 3; else EX slot produces rs -> 1; else MR slot produces rs -> 2; else 0. Unused sources (rr_rs_used[s]=0) get 0 unless rs == PC_REG.
- Priority EX over MR: the youngest producer wins.
- stall_rr = rr_valid && !flush && EX slot valid && is_load && wr && there is some used s with rs == EX.rd != PC_REG.
- Advance (pipe_hold=0): WB<=MR, MR<=EX. EX<=RR fields when rr_valid && !stall_rr && !flush, otherwise an invalid bubble; ex_sel<=computed selects (0 when bubble); ex_bubble<=!(entry valid).
- Hold (pipe_hold=1): all slots, ex_sel and ex_bubble hold. flush is ignored, so upstream keeps flush asserted until the hold ends. The counter does not increment.
- stall_cnt increments by 1 on each advancing edge with stall_rr=1 and saturates at all-ones.
- The register file is write-first, so WB-stage writes need no select.
- After a load-use stall the load sits in MR, and the consumer enters EX with select 2.

## Timing
- Reset: slots invalid, ex_sel=0, ex_bubble=1, stall_cnt=0, and therefore stall_rr=0.
- Reset asserted mid-operation clears everything immediately. The first post-reset advance loads RR normally.
- The selects have one-cycle latency: they are computed in RR and are valid throughout the EX cycle of that instruction.
- stall_rr lasts exactly one advancing cycle per load-use pair, because the load then leaves the EX slot. Back-to-back dependent loads each stall once.
- flush and stall_rr together: flush wins, the bubble is injected, and the counter does not increment.
- Multiple sources can match different slots; each source resolves independently.

## Structure
- Package fwd_pkg holds the select codes (FWD_RF=0, FWD_EXMR=1, FWD_MRWB=2, FWD_PC=3) and the shadow-slot struct {valid, rd, wr, is_load}.
- One sub-module, fwd_src_sel: a combinational per-source priority match that takes one rs, rs_used and the EX/MR slots and returns a 2-bit select. It is instantiated NSRC times by generate.
- The top level holds the slot registers, the stall logic and the counter.

## Test plan
- Reset -> ex_sel=0, ex_bubble=1, stall_cnt=0, stall_rr=0. Assert rst mid-stream -> same values asynchronously.
- ADD r1 then ADD r2,r1,r1 -> second instruction's ex_sel = {1,1}. With one unrelated instruction between them -> {2,2}. With two between -> {0,0}.
- LW r3 then ADD r4,r3,r5 -> stall_rr=1 for one cycle, bubble in EX, then the consumer's ex_sel for r3 = 2, and stall_cnt=1.
- r2 written in EX and MR both, consumer reads r2 -> select 1. Consumer reading r7 -> select 3 even when r7 has a pending write.
- Load-use hazard with pipe_hold=1 for 3 cycles -> stall_rr stays 1, nothing advances, and stall_cnt increments only once, after release.
- flush coincident with a load-use hazard -> EX gets a bubble, stall_cnt is unchanged. Force stall_cnt to all-ones -> it stays saturated.
